// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared mode type, codeword widths and Hamming parity helpers
package enc_pkg;

    typedef enum logic [1:0] {
        MODE8    = 2'b00,
        MODE16   = 2'b01,
        MODE32   = 2'b10,
        MODE_ILL = 2'b11
    } enc_mode_t;

    localparam int CW_W8    = 8;
    localparam int CW_W16   = 16;
    localparam int CW_W32   = 32;
    localparam int DATA_W8  = 4;
    localparam int DATA_W16 = 11;
    localparam int DATA_W32 = 26;

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // parity[k] (k < r) covers every position with bit k set; parity[r] is the overall bit over 1..n-1
    function automatic logic [5:0] hamming_parity(input logic [DATA_W32-1:0] data, input int n, input int r);
        logic [31:0] pos_bits;
        logic [5:0]  p;
        int          j;
        pos_bits = '0;
        p        = '0;
        j        = 0;
        for (int pos = 3; pos < 32; pos++) begin
            if (pos < n && !is_pow2(pos)) begin
                pos_bits[pos] = data[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (k < r) begin
                for (int pos = 1; pos < 32; pos++) begin
                    if (pos[k]) p[k] = p[k] ^ pos_bits[pos];
                end
            end
        end
        p[r] = (^pos_bits) ^ (^p);
        return p;
    endfunction

    function automatic logic [3:0] enc_parity_8(input logic [DATA_W8-1:0] d);
        logic [5:0] p;
        p = hamming_parity({{(DATA_W32-DATA_W8){1'b0}}, d}, CW_W8, 3);
        return p[3:0];
    endfunction

    function automatic logic [4:0] enc_parity_16(input logic [DATA_W16-1:0] d);
        logic [5:0] p;
        p = hamming_parity({{(DATA_W32-DATA_W16){1'b0}}, d}, CW_W16, 4);
        return p[4:0];
    endfunction

    function automatic logic [5:0] enc_parity_32(input logic [DATA_W32-1:0] d);
        return hamming_parity(d, CW_W32, 5);
    endfunction

endpackage

// File: rtl/enc_cw_pack.sv
// rtl/enc_cw_pack.sv - combinational placement of data and parity bits into a zero-padded codeword
module enc_cw_pack
    import enc_pkg::*;
(
    input  logic [DATA_W32-1:0] data,
    input  enc_mode_t           mode,
    input  logic [3:0]          parity_8,
    input  logic [4:0]          parity_16,
    input  logic [5:0]          parity_32,
    output logic [CW_W32-1:0]   cw
);

    always_comb begin
        int         n;
        int         j;
        int         k;
        logic [4:0] p;
        logic       overall;
        cw      = '0;
        j       = 0;
        k       = 0;
        n       = 0;
        p       = '0;
        overall = 1'b0;
        case (mode)
            MODE8: begin
                n       = CW_W8;
                p       = {2'b00, parity_8[2:0]};
                overall = parity_8[3];
            end
            MODE16: begin
                n       = CW_W16;
                p       = {1'b0, parity_16[3:0]};
                overall = parity_16[4];
            end
            MODE32: begin
                n       = CW_W32;
                p       = parity_32[4:0];
                overall = parity_32[5];
            end
            default: begin
                n       = 0;
                p       = '0;
                overall = 1'b0;
            end
        endcase
        // walk positions once: powers of two take the next parity bit, the rest take the next data bit
        for (int pos = 1; pos < CW_W32; pos++) begin
            if (pos < n) begin
                if (is_pow2(pos)) begin
                    cw[pos] = p[k];
                    k++;
                end else begin
                    cw[pos] = data[j];
                    j++;
                end
            end
        end
        cw[0] = overall;
    end

endmodule

// File: rtl/enc_codeword_builder.sv
// rtl/enc_codeword_builder.sv - two-stage SECDED codeword builder with backpressure and counters
module enc_codeword_builder
    import enc_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [25:0]      in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_cw,
    output logic [1:0]       out_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cw_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    logic                s1_valid;
    logic [DATA_W32-1:0] s1_data;
    enc_mode_t           s1_mode;
    logic                s1_ill;
    logic                s1_advances;
    logic                s2_load;
    logic [3:0]          parity_8;
    logic [4:0]          parity_16;
    logic [5:0]          parity_32;
    logic [31:0]         cw;

    // an illegal word always leaves S1 immediately since it never needs the output register
    assign s1_ill      = (s1_mode == MODE_ILL);
    assign s1_advances = s1_valid & (s1_ill | ~out_valid | out_ready);
    assign s2_load     = s1_valid & ~s1_ill & (~out_valid | out_ready);
    assign in_ready    = ~s1_valid | s1_advances;

    assign parity_8  = enc_parity_8(s1_data[DATA_W8-1:0]);
    assign parity_16 = enc_parity_16(s1_data[DATA_W16-1:0]);
    assign parity_32 = enc_parity_32(s1_data);

    enc_cw_pack u_pack (
        .data      (s1_data),
        .mode      (s1_mode),
        .parity_8  (parity_8),
        .parity_16 (parity_16),
        .parity_32 (parity_32),
        .cw        (cw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE8;
            out_valid <= 1'b0;
            out_cw    <= '0;
            out_mode  <= 2'b00;
            cw_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_mode  <= enc_mode_t'(in_mode);
            end else if (s1_advances) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                out_cw    <= cw;
                out_mode  <= s1_mode;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                cw_cnt <= cw_cnt + 1'b1;
            end

            if (s1_valid && s1_ill && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
